csr_intr_ctrl: RTL and testbench

Machine-mode CSR and interrupt sequencer for the 5-stage RV32 core. Holds mstatus/mie/mip/mtvec/mepc/mcause, executes CSR read-modify-writes issued from EX, and runs the trap-entry, MRET and WFI sequences by driving a one-cycle PC redirect and pipeline flush. Sits beside the EX stage and takes the decoder's return/WFI strobes and the external and timer interrupt lines.

---
 rtl/csr_intr_ctrl_if.sv | 32 +++
 rtl/csr_intr_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_csr_intr_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_intr_ctrl_if.sv
// Bus between the EX stage / decoder and the machine-mode CSR and interrupt sequencer.
interface csr_intr_ctrl_if;
  logic        irq_ext;
  logic        irq_timer;
  logic        stall;
  logic [31:0] pc_ex;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        mret;
  logic        wfi;
  logic        wfi_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instret_inc;

  // Core side: drives requests, consumes redirect/stall/read data.
  modport master (
    output irq_ext, irq_timer, stall, pc_ex, csr_en, csr_op, csr_addr,
           csr_wdata, mret, wfi, instret_inc,
    input  csr_rdata, wfi_stall, redirect, redirect_pc
  );

  // Sequencer side.
  modport slave (
    input  irq_ext, irq_timer, stall, pc_ex, csr_en, csr_op, csr_addr,
           csr_wdata, mret, wfi, instret_inc,
    output csr_rdata, wfi_stall, redirect, redirect_pc
  );
endinterface

// File: rtl/csr_intr_ctrl.sv
// Machine-mode CSR file and trap/MRET/WFI sequencer for the RV32 core.
// Optional mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_intr_ctrl #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  csr_intr_ctrl_if.slave  bus
);

  localparam int unsigned XLEN = 32;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
`endif

  localparam logic [XLEN-1:0] CAUSE_EXT = 32'h8000_000B;
  localparam logic [XLEN-1:0] CAUSE_TMR = 32'h8000_0007;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_TRAP  = 2'd1,
    ST_RET   = 2'd2,
    ST_SLEEP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic            r_mie_meie;
  logic            r_mie_mtie;
  logic [XLEN-1:2] r_mtvec;
  logic [XLEN-1:2] r_mepc;
  logic [XLEN-1:0] r_mcause;
`ifdef CSR_COUNTERS_EN
  logic [63:0]     r_mcycle;
  logic [63:0]     r_minstret;
`endif

  logic [1:0]      w_pend;
  logic            w_take;
  logic            w_do_trap;
  logic            w_do_ret;
  logic            w_csr_we;
  logic [XLEN-1:0] w_rdata;
  logic [XLEN-1:0] w_new;
  logic            w_unused;

  // Enabled pending interrupts; external is bit 1 and wins cause selection.
  assign w_pend = {bus.irq_ext & r_mie_meie, bus.irq_timer & r_mie_mtie};
  assign w_take = (|w_pend) & r_mstatus_mie;

  // CSR read mux; also the "old" operand of read-modify-write.
  always_comb begin
    w_rdata = '0;
    case (bus.csr_addr)
      A_MSTATUS: begin
        w_rdata[12:11] = 2'b11;
        w_rdata[7]     = r_mstatus_mpie;
        w_rdata[3]     = r_mstatus_mie;
      end
      A_MIE: begin
        w_rdata[11] = r_mie_meie;
        w_rdata[7]  = r_mie_mtie;
      end
      A_MTVEC:  w_rdata = {r_mtvec, 2'b00};
      A_MEPC:   w_rdata = {r_mepc, 2'b00};
      A_MCAUSE: w_rdata = r_mcause;
      A_MIP: begin
        w_rdata[11] = bus.irq_ext;
        w_rdata[7]  = bus.irq_timer;
      end
`ifdef CSR_COUNTERS_EN
      A_MCYCLE:    w_rdata = r_mcycle[31:0];
      A_MCYCLEH:   w_rdata = r_mcycle[63:32];
      A_MINSTRET:  w_rdata = r_minstret[31:0];
      A_MINSTRETH: w_rdata = r_minstret[63:32];
`endif
      default:  w_rdata = '0;
    endcase
  end

  // New CSR value for write/set/clear.
  always_comb begin
    w_new = w_rdata;
    case (bus.csr_op)
      OP_WRITE: w_new = bus.csr_wdata;
      OP_SET:   w_new = w_rdata | bus.csr_wdata;
      OP_CLEAR: w_new = w_rdata & ~bus.csr_wdata;
      OP_READ:  w_new = w_rdata;
      default:  w_new = w_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state and sequencing strobes; leaving RUN discards any CSR op.
  always_comb begin
    w_state_nxt = r_state;
    w_do_trap   = 1'b0;
    w_do_ret    = 1'b0;
    w_csr_we    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!bus.stall) begin
          if (bus.mret) begin
            w_state_nxt = ST_RET;
            w_do_ret    = 1'b1;
          end else if (w_take) begin
            w_state_nxt = ST_TRAP;
            w_do_trap   = 1'b1;
          end else if (bus.wfi) begin
            w_state_nxt = ST_SLEEP;
          end else if (bus.csr_en && (bus.csr_op != OP_READ)) begin
            w_csr_we = 1'b1;
          end
        end
      end
      ST_TRAP:  w_state_nxt = ST_RUN;
      ST_RET:   w_state_nxt = ST_RUN;
      ST_SLEEP: begin
        if (|w_pend) begin
          if (!r_mstatus_mie) begin
            w_state_nxt = ST_RUN;
          end else if (!bus.stall) begin
            w_state_nxt = ST_TRAP;
            w_do_trap   = 1'b1;
          end
        end
      end
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // Architectural CSRs: trap entry, MRET and CSR writes are mutually exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_meie     <= 1'b0;
      r_mie_mtie     <= 1'b0;
      r_mtvec        <= MTVEC_RST[XLEN-1:2];
      r_mepc         <= '0;
      r_mcause       <= '0;
    end else if (w_do_trap) begin
      r_mepc         <= bus.pc_ex[XLEN-1:2];
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
      r_mcause       <= w_pend[1] ? CAUSE_EXT : CAUSE_TMR;
    end else if (w_do_ret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_csr_we) begin
      case (bus.csr_addr)
        A_MSTATUS: begin
          r_mstatus_mie  <= w_new[3];
          r_mstatus_mpie <= w_new[7];
        end
        A_MIE: begin
          r_mie_meie <= w_new[11];
          r_mie_mtie <= w_new[7];
        end
        A_MTVEC:  r_mtvec  <= w_new[XLEN-1:2];
        A_MEPC:   r_mepc   <= w_new[XLEN-1:2];
        A_MCAUSE: r_mcause <= w_new;
        default:  ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // Free-running counters; a CSR write to either half wins over the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_csr_we && (bus.csr_addr == A_MCYCLE))
        r_mcycle <= {r_mcycle[63:32], w_new};
      else if (w_csr_we && (bus.csr_addr == A_MCYCLEH))
        r_mcycle <= {w_new, r_mcycle[31:0]};
      else
        r_mcycle <= r_mcycle + 64'(1);

      if (w_csr_we && (bus.csr_addr == A_MINSTRET))
        r_minstret <= {r_minstret[63:32], w_new};
      else if (w_csr_we && (bus.csr_addr == A_MINSTRETH))
        r_minstret <= {w_new, r_minstret[31:0]};
      else if (bus.instret_inc)
        r_minstret <= r_minstret + 64'(1);
    end
  end

  assign w_unused = ^bus.pc_ex[1:0];
`else
  assign w_unused = ^{bus.pc_ex[1:0], bus.instret_inc};
`endif

  // Outputs decode straight from the state register so reset drops them at once.
  assign bus.csr_rdata   = w_rdata;
  assign bus.wfi_stall   = (r_state == ST_SLEEP);
  assign bus.redirect    = (r_state == ST_TRAP) || (r_state == ST_RET);
  assign bus.redirect_pc = (r_state == ST_TRAP) ? {r_mtvec, 2'b00} :
                           (r_state == ST_RET)  ? {r_mepc, 2'b00}  : '0;

endmodule

// File: tb/tb_csr_intr_ctrl.sv
// Self-checking bench for csr_intr_ctrl: CSR vector table plus trap/MRET/WFI sequences.
module tb_csr_intr_ctrl;

  localparam logic [31:0] MTVEC = 32'h0000_4000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  csr_intr_ctrl_if bus ();

  csr_intr_ctrl #(.MTVEC_RST(MTVEC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_old;
    logic [31:0] exp_new;
  } vec_t;

  localparam int NVEC = 14;
  vec_t        vecs [NVEC];
  logic [31:0] sb_q [$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    bus.csr_en    = 1'b1;
    bus.csr_op    = op;
    bus.csr_addr  = addr;
    bus.csr_wdata = wd;
    tick();
    bus.csr_en    = 1'b0;
    bus.csr_op    = 2'b00;
  endtask

  task automatic rd(input logic [11:0] addr, output logic [31:0] d);
    bus.csr_addr = addr;
    #1;
    d = bus.csr_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        saw_redir;
    logic [31:0] exp;

    bus.irq_ext = 0; bus.irq_timer = 0; bus.stall = 0; bus.pc_ex = '0;
    bus.csr_en = 0; bus.csr_op = 0; bus.csr_addr = '0; bus.csr_wdata = '0;
    bus.mret = 0; bus.wfi = 0; bus.instret_inc = 0;

    vecs[0]  = '{2'b00, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 32'h0000_1800};
    vecs[1]  = '{2'b01, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 32'h0000_1888};
    vecs[2]  = '{2'b11, 12'h300, 32'h0000_0088, 32'h0000_1888, 32'h0000_1800};
    vecs[3]  = '{2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0880};
    vecs[4]  = '{2'b11, 12'h304, 32'h0000_0080, 32'h0000_0880, 32'h0000_0800};
    vecs[5]  = '{2'b10, 12'h305, 32'h0000_0103, 32'h0000_4000, 32'h0000_4100};
    vecs[6]  = '{2'b11, 12'h305, 32'h0000_0100, 32'h0000_4100, 32'h0000_4000};
    vecs[7]  = '{2'b01, 12'h341, 32'h0000_1237, 32'h0000_0000, 32'h0000_1234};
    vecs[8]  = '{2'b10, 12'h342, 32'h8000_0003, 32'h0000_0000, 32'h8000_0003};
    vecs[9]  = '{2'b01, 12'h342, 32'h0000_0000, 32'h8000_0003, 32'h0000_0000};
    vecs[10] = '{2'b01, 12'h344, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{2'b01, 12'h123, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[12] = '{2'b01, 12'h304, 32'h0000_0000, 32'h0000_0800, 32'h0000_0000};
    vecs[13] = '{2'b00, 12'h305, 32'h0000_FFFF, 32'h0000_4000, 32'h0000_4000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_redirect", 32'(bus.redirect), 32'h0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
    chk("rst_wfi_stall", 32'(bus.wfi_stall), 32'h0);
    rd(12'h300, d); chk("rst_mstatus", d, 32'h0000_1800);
    rd(12'h305, d); chk("rst_mtvec", d, MTVEC);
    rst = 1'b0;
    tick();

    // CSR read-modify-write table: old value same cycle, new value next cycle
    for (int i = 0; i < NVEC; i++) begin
      bus.csr_en    = 1'b1;
      bus.csr_op    = vecs[i].op;
      bus.csr_addr  = vecs[i].addr;
      bus.csr_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_old", i), bus.csr_rdata, vecs[i].exp_old);
      sb_q.push_back(vecs[i].exp_new);
      tick();
      bus.csr_en = 1'b0;
      bus.csr_op = 2'b00;
      #1;
      exp = sb_q.pop_front();
      chk($sformatf("vec%0d_new", i), bus.csr_rdata, exp);
    end

    // Timer interrupt trap entry
    csr_wr(2'b01, 12'h304, 32'h0000_0880);
    csr_wr(2'b01, 12'h300, 32'h0000_0008);
    bus.pc_ex = 32'h0000_0200;
    bus.irq_timer = 1'b1;
    tick();
    bus.irq_timer = 1'b0;
    #1;
    chk("tmr_redirect", 32'(bus.redirect), 32'h1);
    chk("tmr_redirect_pc", bus.redirect_pc, MTVEC);
    tick();
    chk("tmr_redirect_one_cycle", 32'(bus.redirect), 32'h0);
    rd(12'h341, d); chk("tmr_mepc", d, 32'h0000_0200);
    rd(12'h342, d); chk("tmr_mcause", d, 32'h8000_0007);
    rd(12'h300, d); chk("tmr_mstatus", d, 32'h0000_1880);

    // Both interrupts: external wins; then MRET
    csr_wr(2'b01, 12'h300, 32'h0000_0008);
    bus.irq_ext = 1'b1;
    bus.irq_timer = 1'b1;
    rd(12'h344, d); chk("mip_both", d, 32'h0000_0880);
    tick();
    bus.irq_ext = 1'b0;
    bus.irq_timer = 1'b0;
    #1;
    chk("ext_redirect", 32'(bus.redirect), 32'h1);
    tick();
    rd(12'h342, d); chk("ext_mcause", d, 32'h8000_000B);
    rd(12'h300, d); chk("ext_mstatus", d, 32'h0000_1880);
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    #1;
    chk("mret_redirect", 32'(bus.redirect), 32'h1);
    chk("mret_redirect_pc", bus.redirect_pc, 32'h0000_0200);
    tick();
    rd(12'h300, d); chk("mret_mstatus", d, 32'h0000_1888);

    // WFI with MIE=0: wake on external without trap
    csr_wr(2'b01, 12'h300, 32'h0000_0000);
    bus.pc_ex = 32'h0000_0500;
    bus.wfi = 1'b1;
    tick();
    bus.wfi = 1'b0;
    saw_redir = 1'b0;
    chk("wfi_stall_set", 32'(bus.wfi_stall), 32'h1);
    repeat (3) begin
      tick();
      saw_redir = saw_redir | bus.redirect;
      chk("wfi_stall_hold", 32'(bus.wfi_stall), 32'h1);
    end
    bus.irq_ext = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      saw_redir = saw_redir | bus.redirect;
      if (!bus.wfi_stall) break;
    end
    bus.irq_ext = 1'b0;
    chk("wfi_wake", 32'(bus.wfi_stall), 32'h0);
    #1;
    saw_redir = saw_redir | bus.redirect;
    chk("wfi_no_redirect", 32'(saw_redir), 32'h0);
    rd(12'h341, d); chk("wfi_mepc_kept", d, 32'h0000_0200);
    csr_wr(2'b01, 12'h342, 32'h0000_0055);
    rd(12'h342, d); chk("wfi_back_in_run", d, 32'h0000_0055);

    // MRET and interrupt together: RET first, TRAP after
    csr_wr(2'b01, 12'h300, 32'h0000_0088);
    bus.pc_ex = 32'h0000_0600;
    bus.mret = 1'b1;
    bus.irq_timer = 1'b1;
    tick();
    bus.mret = 1'b0;
    #1;
    chk("both_ret_redirect", 32'(bus.redirect), 32'h1);
    chk("both_ret_pc", bus.redirect_pc, 32'h0000_0200);
    tick();
    chk("both_run_gap", 32'(bus.redirect), 32'h0);
    tick();
    bus.irq_timer = 1'b0;
    #1;
    chk("both_trap_redirect", 32'(bus.redirect), 32'h1);
    chk("both_trap_pc", bus.redirect_pc, MTVEC);
    tick();
    rd(12'h341, d); chk("both_mepc", d, 32'h0000_0600);
    rd(12'h342, d); chk("both_mcause", d, 32'h8000_0007);

    // Stall blocks CSR writes
    bus.stall = 1'b1;
    csr_wr(2'b01, 12'h342, 32'h0000_1234);
    bus.stall = 1'b0;
    rd(12'h342, d); chk("stall_no_write", d, 32'h8000_0007);

`ifdef CSR_COUNTERS_EN
    csr_wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd(12'hB80, d); chk("mcycle_carry", d, 32'h0000_0001);
    csr_wr(2'b01, 12'hB02, 32'h0000_000A);
    bus.instret_inc = 1'b1;
    repeat (3) tick();
    bus.instret_inc = 1'b0;
    rd(12'hB02, d); chk("minstret_count", d, 32'h0000_000D);
`else
    csr_wr(2'b01, 12'hB00, 32'h0000_0055);
    rd(12'hB00, d); chk("no_mcycle", d, 32'h0);
    rd(12'hB82, d); chk("no_minstreth", d, 32'h0);
`endif

    // Reset in the middle of TRAP
    csr_wr(2'b01, 12'h305, 32'h0000_8000);
    csr_wr(2'b01, 12'h300, 32'h0000_0008);
    bus.irq_ext = 1'b1;
    tick();
    bus.irq_ext = 1'b0;
    #1;
    chk("rtrap_redirect", 32'(bus.redirect), 32'h1);
    chk("rtrap_pc", bus.redirect_pc, 32'h0000_8000);
    #1;
    rst = 1'b1;
    #1;
    chk("rtrap_redirect_drop", 32'(bus.redirect), 32'h0);
    chk("rtrap_pc_drop", bus.redirect_pc, 32'h0);
    rd(12'h300, d); chk("rtrap_mstatus", d, 32'h0000_1800);
    rd(12'h304, d); chk("rtrap_mie", d, 32'h0);
    rd(12'h305, d); chk("rtrap_mtvec", d, MTVEC);
    rd(12'h341, d); chk("rtrap_mepc", d, 32'h0);
    rd(12'h342, d); chk("rtrap_mcause", d, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("rtrap_post_redirect", 32'(bus.redirect), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
